conv_result_sink: RTL and testbench
===================================

# conv_result_sink

Receiving end of the convolution block's result stream. Captures one complete output frame of `o_en`/`o_conv_result` beats into an internal buffer and flags frame completion. On request it drains the frame in raster order over a valid/ready read port, so downstream logic (BRAM writer, host readout, next layer) can consume results at its own pace. It sits directly after `conv_blk` and uses the same geometry parameters, so it always expects the correct number of beats.

## Interface

Parameters:
- `KERNEL_SIZE`, default `` `KERNEL_SIZE ``: kernel side, used only to size the frame.
- `FM_SIZE`, default `` `FM_SIZE ``: input feature-map side.
- `PADDING`, default `` `PADDING ``: padding.
- `STRIDE`, default `` `STRIDE ``: stride.
- `MAXPOOL`, default `` `MAXPOOL ``: 1 means the upstream block applies 2x2 max-pooling.
- localparam `OUT_SIZE` = ((FM_SIZE - KERNEL_SIZE + 2*PADDING)/STRIDE) + 1.
- localparam `N` = MAXPOOL ? (OUT_SIZE/2)**2 : OUT_SIZE**2. This is the number of words per frame.
- localparam `AW` = max(1, $clog2(N)).

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_arm`, in, 1: start capture of a new frame. Honoured only in IDLE.
- `i_en`, in, 1: result beat valid. Connects to `conv_blk.o_en`.
- `i_data`, in, signed `` `DW ``: result beat. Connects to `conv_blk.o_conv_result`.
- `i_drain`, in, 1: start readout. Honoured only in FULL.
- `i_rd_ready`, in, 1: downstream accepts the current word.
- `o_rd_valid`, out, 1: `o_rd_data` is valid.
- `o_rd_data`, out, signed `` `DW ``: word being read out.
- `o_rd_addr`, out, AW: raster index of `o_rd_data`.
- `o_rd_last`, out, 1: high with the word at index N-1.
- `o_frame_done`, out, 1: one-cycle pulse when word N-1 has been captured.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_overflow`, out, 1: sticky. Set when a beat is dropped.
- `o_max`, out, signed `` `DW ``: largest value captured in the current or last frame.

## Operation

- Storage is an N x `DW` synchronous RAM with a 1-cycle read latency. The write pointer `wr_ptr` and read pointer `rd_ptr` are AW bits wide and count from 0 to N-1.
- FSM states are IDLE, CAPTURE, FULL and DRAIN.
- IDLE:
  - `i_arm`=1 moves the FSM to CAPTURE.
  - The same transition clears `wr_ptr`, clears `o_overflow` and sets `o_max` to the most negative `DW` value.
- CAPTURE:
  - Each cycle with `i_en`=1 writes `i_data` to mem[wr_ptr] and increments `wr_ptr`.
  - The same cycle sets `o_max` to max(`o_max`, `i_data`) using a signed compare.
  - The write to index N-1 moves the FSM to FULL and pulses `o_frame_done` on the next cycle.
- FULL:
  - The FSM waits for `i_drain`=1, then moves to DRAIN with `rd_ptr`=0.
  - `i_arm` is ignored in this state.
- DRAIN:
  - The read port streams indices 0 to N-1.
  - A handshake is `o_rd_valid & i_rd_ready`. Each handshake advances to the next index.
  - The handshake on index N-1 returns the FSM to IDLE. `o_max` keeps its value.
- A beat is dropped when `i_en`=1 arrives in any state other than CAPTURE. Dropped beats:
  - are not stored;
  - set `o_overflow`;
  - leave `o_max` unchanged.
- `i_arm` in CAPTURE, FULL or DRAIN is ignored. `i_drain` outside FULL is ignored.
- The buffer contents are not cleared by reset or by `i_arm`. Only written words are ever read.

## Timing

- Reset values:
  - state is IDLE;
  - `wr_ptr` and `rd_ptr` are 0;
  - `o_rd_valid`, `o_rd_last`, `o_frame_done`, `o_busy` and `o_overflow` are 0;
  - `o_rd_data` and `o_rd_addr` are 0;
  - `o_max` is the most negative `DW` value.
- Reset asserted mid-CAPTURE or mid-DRAIN forces IDLE immediately with the values above.
- Capture accepts one beat per clock with no gaps required. Back-to-back `i_en` for N cycles must all be stored.
- `o_frame_done` is high exactly in the cycle after the edge that sampled the N-th beat. `o_busy` stays high through that cycle.
- `o_rd_valid` rises 2 cycles after the edge that sampled `i_drain`=1 in FULL. Those 2 cycles cover the address phase and the RAM latency.
- Read-port handshake rules:
  - While `o_rd_valid`=1 and `i_rd_ready`=0, `o_rd_data`, `o_rd_addr` and `o_rd_last` hold stable.
  - With `i_rd_ready` held at 1, one word is delivered per clock. This requires a prefetch/skid so that there are no bubbles after the first word.
  - `o_rd_valid` never deasserts before its handshake.
- In the cycle after the last handshake, `o_rd_valid` and `o_busy` are 0 and the FSM is in IDLE.
- Simultaneous `i_arm` and the final handshake in the same cycle: `i_arm` is ignored. The FSM re-arms only from IDLE.
- Simultaneous `i_en` and the transition from IDLE to CAPTURE in the same cycle: the beat is dropped and `o_overflow` is set, because the FSM is still in IDLE.

## Test plan

All scenarios use FM_SIZE=6, KERNEL_SIZE=3, PADDING=0, STRIDE=1.

- **Basic capture and drain (MAXPOOL=0, N=16).**
  - Stimulus: arm, then 16 consecutive beats with values 100..115, then drain with `i_rd_ready`=1.
  - Response: `o_frame_done` pulses 1 cycle after beat 16.
  - Response: 16 consecutive valid words reading 100..115 at addresses 0..15, with `o_rd_last` on address 15.
  - Response: `o_max`=115.
- **Pooled frame size (MAXPOOL=1, N=4).**
  - Stimulus: beats -5, 7, -3, 2 spaced 3 cycles apart.
  - Response: the FSM goes to FULL after the 4th beat; the drain returns -5, 7, -3, 2; `o_max`=7.
- **Backpressure.**
  - Stimulus: during drain, toggle `i_rd_ready` with the pattern 1,0,0,1 repeating.
  - Response: every word is delivered exactly once, in order.
  - Response: outputs stay stable while `i_rd_ready`=0.
  - Response: `o_rd_valid` never drops early.
- **Overflow.**
  - Stimulus: with the FSM in FULL, send 2 extra beats with value 999.
  - Response: `o_overflow`=1.
  - Response: the drain contents are unchanged, with no 999 present.
  - Response: the next `i_arm` clears `o_overflow`.
- **Reset mid-operation.**
  - Stimulus: assert `i_rst` asynchronously after 8 beats (no clock edge needed); release; arm; send a full 16-beat frame.
  - Response: the outputs show reset values immediately.
  - Response: the new frame drains correctly from address 0.
- **Ignored controls.**
  - Stimulus: pulse `i_drain` in CAPTURE, then pulse `i_arm` in FULL.
  - Response: neither changes state.
  - Response: the drain starts only on a later `i_drain` pulse sent while in FULL.

Source files
------------

// File: rtl/conv_result_sink_if.sv
// conv_result_sink_if: capture/readout bundle for conv_result_sink.
// master = producer/consumer side, slave = the sink itself.
`timescale 1ns/1ps
`ifndef DW
`define DW 16
`endif

interface conv_result_sink_if #(
    parameter int AW = 4
) ();
    logic                  i_arm;
    logic                  i_en;
    logic signed [`DW-1:0] i_data;
    logic                  i_drain;
    logic                  i_rd_ready;
    logic                  o_rd_valid;
    logic signed [`DW-1:0] o_rd_data;
    logic [AW-1:0]         o_rd_addr;
    logic                  o_rd_last;
    logic                  o_frame_done;
    logic                  o_busy;
    logic                  o_overflow;
    logic signed [`DW-1:0] o_max;

    modport master (
        output i_arm, i_en, i_data, i_drain, i_rd_ready,
        input  o_rd_valid, o_rd_data, o_rd_addr, o_rd_last,
        input  o_frame_done, o_busy, o_overflow, o_max
    );

    modport slave (
        input  i_arm, i_en, i_data, i_drain, i_rd_ready,
        output o_rd_valid, o_rd_data, o_rd_addr, o_rd_last,
        output o_frame_done, o_busy, o_overflow, o_max
    );
endinterface

// File: rtl/conv_result_sink.sv
// conv_result_sink: buffers one conv_blk output frame, then drains it
// in raster order over valid/ready. Ports: i_clk, i_rst (async high), bus.
`timescale 1ns/1ps
`ifndef DW
`define DW 16
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 3
`endif
`ifndef FM_SIZE
`define FM_SIZE 6
`endif
`ifndef PADDING
`define PADDING 0
`endif
`ifndef STRIDE
`define STRIDE 1
`endif
`ifndef MAXPOOL
`define MAXPOOL 0
`endif

module conv_result_sink #(
    parameter int KERNEL_SIZE = `KERNEL_SIZE,
    parameter int FM_SIZE     = `FM_SIZE,
    parameter int PADDING     = `PADDING,
    parameter int STRIDE      = `STRIDE,
    parameter int MAXPOOL     = `MAXPOOL
) (
    input  logic             i_clk,
    input  logic             i_rst,
    conv_result_sink_if.slave bus
);
    localparam int OUT_SIZE =
        ((FM_SIZE - KERNEL_SIZE + 2*PADDING) / STRIDE) + 1;
    localparam int HALF = OUT_SIZE / 2;
    localparam int N = (MAXPOOL != 0) ? HALF*HALF
                                      : OUT_SIZE*OUT_SIZE;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST = AW'(N-1);
    localparam logic signed [`DW-1:0] MIN =
        {1'b1, {(`DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE, CAPTURE, FULL, DRAIN
    } state_t;

    state_t state_q, state_d;

    logic signed [`DW-1:0] mem [N];
    logic signed [`DW-1:0] ram_q;

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  iss_done;
    logic                  s1_vld;
    logic [AW-1:0]         s1_addr;

    logic                  rd_valid;
    logic signed [`DW-1:0] rd_data;
    logic [AW-1:0]         rd_addr;
    logic                  rd_last;
    logic                  frame_done;
    logic                  overflow;
    logic signed [`DW-1:0] max_q;

    logic start_cap;
    logic wr_en;
    logic start_drain;
    logic hs;
    logic out_take;
    logic s1_move;
    logic issue;
    logic drop;

    // ram_q acts as the prefetch slot (s1) in front of the output
    // register, so a stall freezes both and ready=1 gives no bubbles.
    always_comb begin
        state_d     = state_q;
        start_cap   = 1'b0;
        wr_en       = 1'b0;
        start_drain = 1'b0;
        issue       = 1'b0;
        hs          = rd_valid & bus.i_rd_ready;
        out_take    = ~rd_valid | hs;
        s1_move     = s1_vld & out_take;
        drop        = bus.i_en & (state_q != CAPTURE);
        unique case (state_q)
            IDLE: begin
                if (bus.i_arm) begin
                    state_d   = CAPTURE;
                    start_cap = 1'b1;
                end
            end
            CAPTURE: begin
                if (bus.i_en) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST) state_d = FULL;
                end
            end
            FULL: begin
                if (bus.i_drain) begin
                    state_d     = DRAIN;
                    start_drain = 1'b1;
                end
            end
            DRAIN: begin
                issue = ~iss_done & (~s1_vld | s1_move);
                if (hs && rd_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            iss_done   <= 1'b0;
            s1_vld     <= 1'b0;
            s1_addr    <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_addr    <= '0;
            rd_last    <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            max_q      <= MIN;
        end else begin
            frame_done <= wr_en & (wr_ptr == LAST);

            // a beat arriving with i_arm is still dropped
            if (start_cap) begin
                wr_ptr   <= '0;
                overflow <= drop;
                max_q    <= MIN;
            end else if (drop) begin
                overflow <= 1'b1;
            end

            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                if (bus.i_data > max_q) max_q <= bus.i_data;
            end

            if (start_drain) begin
                rd_ptr   <= '0;
                iss_done <= 1'b0;
                s1_vld   <= 1'b0;
                rd_valid <= 1'b0;
            end else begin
                if (issue) begin
                    s1_addr  <= rd_ptr;
                    iss_done <= (rd_ptr == LAST);
                    if (rd_ptr != LAST) rd_ptr <= rd_ptr + 1'b1;
                end

                if (issue)        s1_vld <= 1'b1;
                else if (s1_move) s1_vld <= 1'b0;

                if (s1_move) begin
                    rd_valid <= 1'b1;
                    rd_data  <= ram_q;
                    rd_addr  <= s1_addr;
                    rd_last  <= (s1_addr == LAST);
                end else if (hs) begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= bus.i_data;
        if (issue) ram_q <= mem[rd_ptr];
    end

    assign bus.o_rd_valid   = rd_valid;
    assign bus.o_rd_data    = rd_data;
    assign bus.o_rd_addr    = rd_addr;
    assign bus.o_rd_last    = rd_last;
    assign bus.o_frame_done = frame_done;
    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_overflow   = overflow;
    assign bus.o_max        = max_q;
endmodule

// File: tb/tb_conv_result_sink.sv
// tb_conv_result_sink: directed checks of capture, drain, backpressure,
// overflow, async reset and pooled frame size.
`timescale 1ns/1ps
`ifndef DW
`define DW 16
`endif

module tb_conv_result_sink;
    localparam int DW = `DW;
    localparam int MINV = -(1 << (DW-1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                 sel;
    logic                 arm;
    logic                 en;
    logic signed [DW-1:0] data;
    logic                 drain;
    logic                 rdy;

    conv_result_sink_if #(.AW(4)) b0 ();
    conv_result_sink_if #(.AW(2)) b1 ();

    assign b0.i_arm      = arm & ~sel;
    assign b0.i_en       = en & ~sel;
    assign b0.i_data     = data;
    assign b0.i_drain    = drain & ~sel;
    assign b0.i_rd_ready = rdy & ~sel;
    assign b1.i_arm      = arm & sel;
    assign b1.i_en       = en & sel;
    assign b1.i_data     = data;
    assign b1.i_drain    = drain & sel;
    assign b1.i_rd_ready = rdy & sel;

    conv_result_sink #(
        .KERNEL_SIZE(3), .FM_SIZE(6), .PADDING(0),
        .STRIDE(1), .MAXPOOL(0)
    ) u0 (
        .i_clk(clk), .i_rst(rst), .bus(b0)
    );

    conv_result_sink #(
        .KERNEL_SIZE(3), .FM_SIZE(6), .PADDING(0),
        .STRIDE(1), .MAXPOOL(1)
    ) u1 (
        .i_clk(clk), .i_rst(rst), .bus(b1)
    );

    logic                 m_valid;
    logic signed [DW-1:0] m_data;
    logic [3:0]           m_addr;
    logic                 m_last;
    logic                 m_done;
    logic                 m_busy;
    logic                 m_ovf;
    logic signed [DW-1:0] m_max;

    assign m_valid = sel ? b1.o_rd_valid : b0.o_rd_valid;
    assign m_data  = sel ? b1.o_rd_data : b0.o_rd_data;
    assign m_addr  = sel ? {2'b00, b1.o_rd_addr} : b0.o_rd_addr;
    assign m_last  = sel ? b1.o_rd_last : b0.o_rd_last;
    assign m_done  = sel ? b1.o_frame_done : b0.o_frame_done;
    assign m_busy  = sel ? b1.o_busy : b0.o_busy;
    assign m_ovf   = sel ? b1.o_overflow : b0.o_overflow;
    assign m_max   = sel ? b1.o_max : b0.o_max;

    int n_chk = 0;
    int n_bad = 0;
    int exp_q [16];

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic arm_it;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic beat(input int v);
        en   = 1'b1;
        data = DW'(v);
        tick();
        en   = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_vld"}, m_valid, 0);
        check({tag, "_last"}, m_last, 0);
        check({tag, "_done"}, m_done, 0);
        check({tag, "_busy"}, m_busy, 0);
        check({tag, "_ovf"}, m_ovf, 0);
        check({tag, "_data"}, m_data, 0);
        check({tag, "_addr"}, m_addr, 0);
        check({tag, "_max"}, m_max, MINV);
    endtask

    task automatic drain_chk(input int n, input bit bp,
                             input string tag);
        int cnt = 0;
        int k = 0;
        int first = -1;
        int lastc = -1;
        bit stall = 1'b0;
        logic signed [DW-1:0] sd;
        logic [3:0] sa;
        logic sl;
        sd = '0;
        sa = '0;
        sl = 1'b0;
        drain = 1'b1;
        tick();
        drain = 1'b0;
        check({tag, "_lat0"}, m_valid, 0);
        tick();
        check({tag, "_lat1"}, m_valid, 0);
        tick();
        check({tag, "_lat2"}, m_valid, 1);
        while (cnt < n && k < 200) begin
            check({tag, "_vld"}, m_valid, 1);
            if (stall) begin
                check({tag, "_hold_d"}, m_data, sd);
                check({tag, "_hold_a"}, m_addr, sa);
                check({tag, "_hold_l"}, m_last, sl);
            end
            rdy = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (m_valid && rdy) begin
                check({tag, "_data"}, m_data, exp_q[cnt]);
                check({tag, "_addr"}, m_addr, cnt);
                check({tag, "_last"}, m_last, (cnt == n-1) ? 1 : 0);
                if (first < 0) first = k;
                lastc = k;
                cnt++;
            end
            stall = m_valid && !rdy;
            sd = m_data;
            sa = m_addr;
            sl = m_last;
            k++;
            tick();
        end
        rdy = 1'b0;
        check({tag, "_count"}, cnt, n);
        if (!bp) check({tag, "_gap"}, lastc - first, n-1);
        check({tag, "_vend"}, m_valid, 0);
        check({tag, "_bend"}, m_busy, 0);
    endtask

    initial begin
        sel   = 1'b0;
        arm   = 1'b0;
        en    = 1'b0;
        data  = '0;
        drain = 1'b0;
        rdy   = 1'b0;
        rst   = 1'b1;
        repeat (2) tick();
        chk_reset("rst0");
        sel = 1'b1;
        chk_reset("rst1");
        sel = 1'b0;
        rst = 1'b0;
        tick();

        // basic frame, stray drain in CAPTURE
        arm_it();
        check("s1_busy", m_busy, 1);
        check("s1_max0", m_max, MINV);
        for (int i = 0; i < 16; i++) begin
            en    = 1'b1;
            data  = DW'(100 + i);
            drain = (i == 5);
            if (i == 15) check("s1_done_early", m_done, 0);
            tick();
        end
        en    = 1'b0;
        drain = 1'b0;
        check("s1_done", m_done, 1);
        check("s1_busy_done", m_busy, 1);
        check("s1_novld", m_valid, 0);
        check("s1_max", m_max, 115);
        tick();
        check("s1_done_once", m_done, 0);
        check("s1_full", m_busy, 1);

        // dropped beats and ignored arm in FULL
        beat(999);
        beat(999);
        check("ov_set", m_ovf, 1);
        check("ov_max", m_max, 115);
        arm_it();
        check("ov_arm_ign", m_ovf, 1);
        tick();
        tick();
        check("full_wait", m_valid, 0);
        check("full_busy", m_busy, 1);
        for (int i = 0; i < 16; i++) exp_q[i] = 100 + i;
        drain_chk(16, 1'b0, "s1");
        check("s1_max_kept", m_max, 115);

        // rearm clears overflow; backpressured drain
        arm_it();
        check("ov_clr", m_ovf, 0);
        check("bp_max0", m_max, MINV);
        for (int i = 0; i < 16; i++) begin
            exp_q[i] = 50 - 9*i;
            beat(exp_q[i]);
        end
        tick();
        check("bp_max", m_max, 50);
        drain_chk(16, 1'b1, "bp");

        // async reset mid-capture
        arm_it();
        for (int i = 0; i < 8; i++) beat(300 + i);
        check("rs_busy", m_busy, 1);
        check("rs_max", m_max, 307);
        #2 rst = 1'b1;
        #1 chk_reset("rs_now");
        tick();
        rst = 1'b0;
        tick();
        arm_it();
        for (int i = 0; i < 16; i++) begin
            exp_q[i] = 1000 + i;
            beat(exp_q[i]);
        end
        drain_chk(16, 1'b0, "rs");
        check("rs_max2", m_max, 1015);

        // pooled frame, N=4, spaced beats
        sel = 1'b1;
        exp_q[0] = -5;
        exp_q[1] = 7;
        exp_q[2] = -3;
        exp_q[3] = 2;
        arm_it();
        for (int i = 0; i < 4; i++) begin
            beat(exp_q[i]);
            if (i < 3) begin
                check("mp_nodone", m_done, 0);
                tick();
                tick();
            end
        end
        check("mp_done", m_done, 1);
        tick();
        tick();
        check("mp_full", m_busy, 1);
        check("mp_max", m_max, 7);
        drain_chk(4, 1'b0, "mp");
        check("mp_max2", m_max, 7);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
